// File: rtl/fifo_read_if.sv
// rtl/fifo_read_if.sv - signal bundle between the frame receiver and its controller
interface fifo_read_if;
   logic [7:0]  fifo_rxd;
   logic        fifo_rxen;
   logic        rs;
   logic [11:0] exp_len;
   logic        rd;
   logic [3:0]  so;
   logic [11:0] rx_len;
   logic [7:0]  rx_sum;
   logic        head_ok;
   logic        err;
   logic [5:0]  rd_addr;
   logic [7:0]  rd_data;

   modport master (
      output fifo_rxd, fifo_rxen, rs, exp_len, rd_addr,
      input  rd, so, rx_len, rx_sum, head_ok, err, rd_data
   );

   modport slave (
      input  fifo_rxd, fifo_rxen, rs, exp_len, rd_addr,
      output rd, so, rx_len, rx_sum, head_ok, err, rd_data
   );
endinterface

// File: rtl/fifo_read.sv
// rtl/fifo_read.sv - frame receiver: buffers a byte burst, checks length, header and XOR sum
module fifo_read (
   input  logic       clk,
   input  logic       rst,
   fifo_read_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_RECV  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_start;
   logic        w_capture;
   logic        w_store;
   logic        w_head;

   logic [11:0] r_count;
   logic [7:0]  r_acc;
   logic        r_ovf;
   logic [7:0]  r_b0;
   logic [7:0]  r_b1;
   logic [7:0]  r_buf [0:63];
   logic [7:0]  r_rd_data;

   logic [11:0] r_rx_len;
   logic [7:0]  r_rx_sum;
   logic        r_head_ok;
   logic        r_err;

   // Next-state and capture strobes; rs low aborts any pending receive
   always_comb begin
      w_next    = S_IDLE;
      w_start   = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.rs) begin
               w_next  = S_WAIT;
               w_start = 1'b1;
            end
         end
         S_WAIT: begin
            if (!bus.rs) begin
               w_next = S_IDLE;
            end else if (bus.fifo_rxen) begin
               w_next    = S_RECV;
               w_capture = 1'b1;
            end else begin
               w_next = S_WAIT;
            end
         end
         S_RECV: begin
            if (!bus.rs) begin
               w_next = S_IDLE;
            end else if (bus.fifo_rxen) begin
               w_next    = S_RECV;
               w_capture = 1'b1;
            end else begin
               w_next = S_CHECK;
            end
         end
         S_CHECK: w_next = S_DONE;
         S_DONE:  w_next = bus.rs ? S_DONE : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_store = w_capture && (r_count < 12'd64);
   assign w_head  = (r_b0 == 8'h55) && (r_b1 == 8'hAA) && (r_count >= 12'd2);

   // State register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // Frame accumulators: byte count (saturating), XOR sum, overflow and the two header bytes
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= 12'd0;
         r_acc   <= 8'd0;
         r_ovf   <= 1'b0;
         r_b0    <= 8'd0;
         r_b1    <= 8'd0;
      end else if (w_start) begin
         r_count <= 12'd0;
         r_acc   <= 8'd0;
         r_ovf   <= 1'b0;
      end else if (w_capture) begin
         r_acc <= r_acc ^ bus.fifo_rxd;
         if (r_count >= 12'd64)  r_ovf   <= 1'b1;
         if (r_count != 12'hFFF) r_count <= r_count + 12'd1;
         if (r_count == 12'd0)   r_b0    <= bus.fifo_rxd;
         if (r_count == 12'd1)   r_b1    <= bus.fifo_rxd;
      end
   end

   // Result registers, updated only on the CHECK to DONE edge
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rx_len  <= 12'd0;
         r_rx_sum  <= 8'd0;
         r_head_ok <= 1'b0;
         r_err     <= 1'b0;
      end else if (r_state == S_CHECK) begin
         r_rx_len  <= r_count;
         r_rx_sum  <= r_acc;
         r_head_ok <= w_head;
         r_err     <= r_ovf || (r_count != bus.exp_len);
      end
   end

   // Frame buffer write; contents intentionally survive reset
   always_ff @(posedge clk) begin
      if (w_store) r_buf[r_count[5:0]] <= bus.fifo_rxd;
   end

   // Registered readback; a same-cycle write to the same address returns the old byte
   always_ff @(posedge clk) begin
      if (!rst) r_rd_data <= 8'd0;
      else      r_rd_data <= r_buf[bus.rd_addr];
   end

   assign bus.rd      = (r_state == S_DONE);
   assign bus.so      = {1'b0, r_state};
   assign bus.rx_len  = r_rx_len;
   assign bus.rx_sum  = r_rx_sum;
   assign bus.head_ok = r_head_ok;
   assign bus.err     = r_err;
   assign bus.rd_data = r_rd_data;

endmodule

// File: tb/tb_fifo_read.sv
// tb/tb_fifo_read.sv - scoreboard bench for fifo_read
module tb_fifo_read;

   typedef struct {
      int len;
      int sum;
      int head;
      int err;
   } exp_t;

   logic clk;
   logic rst;
   fifo_read_if bus ();

   fifo_read dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t       sb [$];
   int         n_cmp;
   int         n_bad;
   logic [7:0] frame [0:127];
   logic       rd_q;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: on each rising rd, pop the expected result and compare
   initial begin
      exp_t e;
      rd_q = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && bus.rd && !rd_q) begin
            if (sb.size() == 0) begin
               check("unexpected_rd", 1, 0);
            end else begin
               e = sb.pop_front();
               check("rx_len",  int'(bus.rx_len),  e.len);
               check("rx_sum",  int'(bus.rx_sum),  e.sum);
               check("head_ok", int'(bus.head_ok), e.head);
               check("err",     int'(bus.err),     e.err);
            end
         end
         rd_q = bus.rd;
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic run_frame(input int n, input int exp_len, input int sum,
                            input int head, input int err);
      exp_t e;
      e.len = n; e.sum = sum; e.head = head; e.err = err;
      sb.push_back(e);
      bus.exp_len = 12'(exp_len);
      bus.rs = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.fifo_rxd  = frame[i];
         bus.fifo_rxen = 1'b1;
      end
      @(posedge clk); #1;
      bus.fifo_rxen = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rd_after_1_edge", int'(bus.rd), 0);
      check("so_check", int'(bus.so), 3);
      @(posedge clk);
      @(negedge clk);
      check("rd_after_2_edges", int'(bus.rd), 1);
      @(posedge clk); #1;
      bus.rs = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("so_idle_after_done", int'(bus.so), 0);
   endtask

   task automatic readback(input int addr, input int exp);
      @(posedge clk); #1;
      bus.rd_addr = 6'(addr);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rd_data[%0d]", addr), int'(bus.rd_data), exp);
   endtask

   task automatic load(input logic [7:0] b [12], input int n);
      for (int i = 0; i < n; i++) frame[i] = b[i];
   endtask

   initial begin
      logic [7:0] f1 [12];
      logic [7:0] f2 [12];
      f1 = '{8'h55, 8'hAA, 8'hFF, 8'h14, 8'h86, 8'h84, 8'h33, 8'h44, 8'h55, 8'h66, 8'h3D, 8'h8C};
      f2 = '{8'h35, 8'h3A, 8'h39, 8'h34, 8'h36, 8'h34, 8'h33, 8'h34, 8'h35, 8'h36, 8'h3D, 8'h00};
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      bus.fifo_rxd = 8'd0;
      bus.fifo_rxen = 1'b0;
      bus.rs = 1'b0;
      bus.exp_len = 12'd0;
      bus.rd_addr = 6'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_rd", int'(bus.rd), 0);
      check("reset_so", int'(bus.so), 0);
      check("reset_rx_len", int'(bus.rx_len), 0);
      check("reset_rx_sum", int'(bus.rx_sum), 0);
      check("reset_head_ok", int'(bus.head_ok), 0);
      check("reset_err", int'(bus.err), 0);
      check("reset_rd_data", int'(bus.rd_data), 0);
      #1 rst = 1'b1;

      // Good headed frame, exact length
      load(f1, 12);
      run_frame(12, 12, 8'hE3, 1, 0);
      readback(11, 8'h8C);
      readback(0, 8'h55);

      // Frame without header
      load(f2, 11);
      run_frame(11, 11, 8'h39, 0, 0);
      readback(10, 8'h3D);

      // Length mismatch
      load(f1, 12);
      run_frame(12, 13, 8'hE3, 1, 1);

      // Overflow: 70 bytes of 0..69, XOR of 0..69 is 1
      for (int i = 0; i < 70; i++) frame[i] = 8'(i);
      run_frame(70, 70, 8'h01, 0, 1);
      readback(63, 8'h3F);
      readback(5, 8'h05);

      // Abort after 5 bytes of RECV
      @(posedge clk); #1;
      bus.exp_len = 12'd5;
      bus.rs = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         bus.fifo_rxd  = 8'hA0 + 8'(i);
         bus.fifo_rxen = 1'b1;
      end
      @(posedge clk); #1;
      bus.rs = 1'b0;
      bus.fifo_rxen = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_so", int'(bus.so), 0);
      check("abort_rd", int'(bus.rd), 0);
      check("abort_rx_len", int'(bus.rx_len), 70);
      check("abort_rx_sum", int'(bus.rx_sum), 8'h01);
      check("abort_err", int'(bus.err), 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("abort_rd_later", int'(bus.rd), 0);

      // Reset mid-RECV
      @(posedge clk); #1;
      bus.rd_addr = 6'd63;
      bus.rs = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         bus.fifo_rxd  = 8'h11;
         bus.fifo_rxen = 1'b1;
      end
      check("pre_reset_so", int'(bus.so), 2);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_so", int'(bus.so), 0);
      check("midrst_rd", int'(bus.rd), 0);
      check("midrst_rx_len", int'(bus.rx_len), 0);
      check("midrst_rx_sum", int'(bus.rx_sum), 0);
      check("midrst_head_ok", int'(bus.head_ok), 0);
      check("midrst_err", int'(bus.err), 0);
      check("midrst_rd_data", int'(bus.rd_data), 0);
      #1;
      rst = 1'b1;
      bus.rs = 1'b0;
      bus.fifo_rxen = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
